// File: rtl/spi_reg_responder_pkg.sv
// Shared types and frame geometry for the SPI register responder.
package spi_reg_responder_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int RW_BIT     = 15;
  localparam int CNT_W      = 5;

  // Bit-counter values, as SCLK rises seen before the current one
  localparam logic [CNT_W-1:0] CNT_HDR_LAST   = CNT_W'(FRAME_BITS - DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_FIRST = CNT_W'(FRAME_BITS - DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [DATA_BITS-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser for SCLK/CS_N/MOSI with edge pulses on the synchronised copies.
module spi_in_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sclk,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_mosi_s
);

  // [0],[1] synchroniser, [2] previous synchronised value for edge detection
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  // CS history resets to "asserted" so a CS already low at reset release
  // never produces a fall; a CS that is high just yields an ignored rise.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], i_sclk};
      cs_q   <= {cs_q[1:0], i_cs_n};
      mosi_q <= {mosi_q[0], i_mosi};
    end
  end

  assign o_sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign o_sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign o_cs_fall   = ~cs_q[1] & cs_q[2];
  assign o_cs_rise   = cs_q[1] & ~cs_q[2];
  assign o_mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder: 16-bit R/W + 7-bit address + 8-bit data frames onto a small register file.
// Optional frame counter output enabled by SPI_REG_RESPONDER_FRAME_CNT_EN.
module spi_reg_responder
  import spi_reg_responder_pkg::*;
#(
  parameter int          REG_DEPTH    = 16,
  parameter logic [6:0]  WHOAMI_ADDR  = 7'h78,
  parameter logic [7:0]  WHOAMI_VALUE = 8'h5A
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_sclk,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_miso_oe,
  output logic        o_busy,
  output logic        o_wr_strobe,
  output logic [6:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  output logic        o_frame_error
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_count
`endif
);

  localparam int    IDX_W   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam addr_t DEPTH_A = addr_t'(REG_DEPTH);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_in_sync u_sync (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_sclk      (i_sclk),
    .i_cs_n      (i_cs_n),
    .i_mosi      (i_mosi),
    .o_sclk_rise (sclk_rise),
    .o_sclk_fall (sclk_fall),
    .o_cs_fall   (cs_fall),
    .o_cs_rise   (cs_rise),
    .o_mosi_s    (mosi_s)
  );

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  data_t            rx_q;
  data_t            tx_q;
  logic             rw_q;
  addr_t            addr_q;
  logic             commit_pend_q;
  logic             miso_oe_q;
  logic             busy_q;
  logic             wr_strobe_q;
  addr_t            wr_addr_q;
  data_t            wr_data_q;
  logic             frame_err_q;
  data_t            regs_q [REG_DEPTH];
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
  logic [15:0]      frame_cnt_q;
`endif

  // Header as it will stand once the current MOSI bit is shifted in
  data_t hdr_d;
  addr_t hdr_addr_d;
  logic  hdr_rw_d;
  data_t rd_data_d;
  logic  wr_ok_d;

  assign hdr_d      = {rx_q[DATA_BITS-2:0], mosi_s};
  assign hdr_addr_d = hdr_d[ADDR_BITS-1:0];
  assign hdr_rw_d   = hdr_d[RW_BIT-DATA_BITS];

  always_comb begin
    rd_data_d = '0;
    if (hdr_addr_d == WHOAMI_ADDR)
      rd_data_d = WHOAMI_VALUE;
    else if (hdr_addr_d < DEPTH_A)
      rd_data_d = regs_q[hdr_addr_d[IDX_W-1:0]];
  end

  assign wr_ok_d = !rw_q && (addr_q < DEPTH_A) && (addr_q != WHOAMI_ADDR);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      commit_pend_q <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_err_q   <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_q   <= ST_ADDR;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end

        ST_ADDR, ST_DATA: begin
          if (cs_rise) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (sclk_rise) begin
            rx_q      <= hdr_d;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (state_q == ST_ADDR && bit_cnt_q == CNT_HDR_LAST) begin
              state_q   <= ST_DATA;
              rw_q      <= hdr_rw_d;
              addr_q    <= hdr_addr_d;
              tx_q      <= rd_data_d;
              miso_oe_q <= hdr_rw_d;
            end else if (state_q == ST_DATA && bit_cnt_q == CNT_FRAME_LAST) begin
              state_q       <= ST_DONE;
              commit_pend_q <= 1'b1;
              miso_oe_q     <= 1'b0;
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
              frame_cnt_q   <= frame_cnt_q + 16'd1;
`endif
            end
          end else if (sclk_fall && state_q == ST_DATA && bit_cnt_q != CNT_DATA_FIRST) begin
            // The fall right after the 8th rise keeps bit7; the master samples it on rise 9
            tx_q <= {tx_q[DATA_BITS-2:0], 1'b0};
          end
        end

        ST_DONE: begin
          if (commit_pend_q) begin
            commit_pend_q <= 1'b0;
            if (wr_ok_d) begin
              regs_q[addr_q[IDX_W-1:0]] <= rx_q;
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= addr_q;
              wr_data_q   <= rx_q;
            end
          end
          if (cs_rise) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_miso        = miso_oe_q & tx_q[DATA_BITS-1];
  assign o_miso_oe     = miso_oe_q;
  assign o_busy        = busy_q;
  assign o_wr_strobe   = wr_strobe_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_frame_error = frame_err_q;
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
  assign o_frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder against an array-based register model.
module tb_spi_reg_responder;

  localparam int HP     = 6;   // SCLK half period in i_clock cycles
  localparam int OE_LEN = 16 * HP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sclk = 1'b0;
  logic        i_cs_n = 1'b1;
  logic        i_mosi = 1'b0;
  logic        o_miso, o_miso_oe, o_busy, o_wr_strobe, o_frame_error;
  logic [6:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
  logic [15:0] o_frame_count;
`endif

  spi_reg_responder dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_sclk        (i_sclk),
    .i_cs_n        (i_cs_n),
    .i_mosi        (i_mosi),
    .o_miso        (o_miso),
    .o_miso_oe     (o_miso_oe),
    .o_busy        (o_busy),
    .o_wr_strobe   (o_wr_strobe),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_frame_error (o_frame_error)
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
    ,
    .o_frame_count (o_frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int strobe_tot = 0;
  int ferr_tot   = 0;
  int oe_tot     = 0;
  int model_fc   = 0;
  logic [7:0] mreg [16];

  always @(negedge clk) begin
    if (!rst) begin
      if (o_wr_strobe)   strobe_tot++;
      if (o_frame_error) ferr_tot++;
      if (o_miso_oe)     oe_tot++;
    end
  end

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'h78) return 8'h5A;
    if (a < 7'd16)  return mreg[a[3:0]];
    return 8'h00;
  endfunction

  task automatic sclk_bit(input logic b, output logic m);
    i_mosi = b;
    repeat (HP) @(negedge clk);
    m = o_miso;
    i_sclk = 1'b1;
    repeat (HP) @(negedge clk);
    i_sclk = 1'b0;
  endtask

  task automatic frame(input logic [15:0] w, input int nrise, output logic [7:0] rb);
    logic m;
    rb = '0;
    i_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      sclk_bit((i < 16) ? w[15-i] : 1'b0, m);
      if (i >= 8 && i < 16) rb = {rb[6:0], m};
    end
    repeat (HP) @(negedge clk);
    i_cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
    if (nrise >= 16) begin
      model_fc++;
      if (!w[15] && w[14:8] < 7'd16) mreg[w[11:8]] = w[7:0];
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({o_miso, o_miso_oe, o_busy, o_wr_strobe, o_frame_error} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b want 00000", {o_miso, o_miso_oe, o_busy, o_wr_strobe, o_frame_error});
    end
    checks++;
    if (o_wr_addr !== 7'h00 || o_wr_data !== 8'h00) begin
      fails++; $display("FAIL reset_wr got %h/%h want 00/00", o_wr_addr, o_wr_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [7:0] rb;
    int s0, o0;
    s0 = strobe_tot; o0 = oe_tot;
    frame(16'h0932, 16, rb);
    checks++;
    if (strobe_tot - s0 != 1 || o_wr_addr !== 7'h09 || o_wr_data !== 8'h32) begin
      fails++; $display("FAIL write_0932 strobes %0d addr %h data %h want 1 09 32", strobe_tot - s0, o_wr_addr, o_wr_data);
    end
    checks++;
    if (oe_tot != o0) begin
      fails++; $display("FAIL write_oe got %0d oe cycles want 0", oe_tot - o0);
    end
    o0 = oe_tot;
    frame(16'h8900, 16, rb);
    checks++;
    if (rb !== 8'h32) begin
      fails++; $display("FAIL read_0932 got %h want 32", rb);
    end
    checks++;
    if (oe_tot - o0 != OE_LEN) begin
      fails++; $display("FAIL read_oe_len got %0d want %0d", oe_tot - o0, OE_LEN);
    end
  endtask

  task automatic test_whoami();
    logic [7:0] rb;
    int s0;
    s0 = strobe_tot;
    frame(16'h78FF, 16, rb);
    checks++;
    if (strobe_tot != s0) begin
      fails++; $display("FAIL whoami_write_strobe got %0d want 0", strobe_tot - s0);
    end
    frame(16'hF800, 16, rb);
    checks++;
    if (rb !== 8'h5A) begin
      fails++; $display("FAIL whoami_read got %h want 5a", rb);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] rb;
    int s0;
    s0 = strobe_tot;
    frame(16'h20AB, 16, rb);
    checks++;
    if (strobe_tot != s0) begin
      fails++; $display("FAIL oor_write_strobe got %0d want 0", strobe_tot - s0);
    end
    frame(16'hA000, 16, rb);
    checks++;
    if (rb !== 8'h00) begin
      fails++; $display("FAIL oor_read got %h want 00", rb);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rb;
    logic m;
    int s0, f0;
    s0 = strobe_tot; f0 = ferr_tot;
    i_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 5; i++) sclk_bit(1'b0, m);
    checks++;
    if (o_busy !== 1'b1) begin
      fails++; $display("FAIL abort_busy_mid got %b want 1", o_busy);
    end
    i_cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
    checks++;
    if (ferr_tot - f0 != 1 || strobe_tot != s0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL abort ferr %0d strobes %0d busy %b want 1 0 0", ferr_tot - f0, strobe_tot - s0, o_busy);
    end
    frame(16'h0155, 16, rb);
    checks++;
    if (strobe_tot - s0 != 1 || o_wr_addr !== 7'h01 || o_wr_data !== 8'h55) begin
      fails++; $display("FAIL after_abort_write strobes %0d addr %h data %h want 1 01 55", strobe_tot - s0, o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rb;
    logic m;
    logic [15:0] w;
    int s0, f0;
    frame(16'h0311, 16, rb);
    s0 = strobe_tot; f0 = ferr_tot;
    w = 16'h0377;
    i_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 12; i++) sclk_bit(w[15-i], m);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_miso, o_miso_oe, o_busy, o_wr_strobe, o_frame_error} !== 5'b0 ||
        o_wr_addr !== 7'h00 || o_wr_data !== 8'h00) begin
      fails++; $display("FAIL midreset_outputs got %b %h %h want all zero",
                        {o_miso, o_miso_oe, o_busy, o_wr_strobe, o_frame_error}, o_wr_addr, o_wr_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    for (int i = 12; i < 16; i++) sclk_bit(w[15-i], m);
    checks++;
    if (o_busy !== 1'b0) begin
      fails++; $display("FAIL midreset_no_frame busy got %b want 0", o_busy);
    end
    i_cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
    checks++;
    if (strobe_tot != s0 || ferr_tot != f0) begin
      fails++; $display("FAIL midreset_pulses strobes %0d ferr %0d want 0 0", strobe_tot - s0, ferr_tot - f0);
    end
    frame(16'h8300, 16, rb);
    checks++;
    if (rb !== 8'h00) begin
      fails++; $display("FAIL midreset_reg3 got %h want 00", rb);
    end
    model_fc = 1;
  endtask

  task automatic test_extra_edges();
    logic [7:0] rb;
    int s0;
    s0 = strobe_tot;
    frame(16'h0A5C, 21, rb);
    checks++;
    if (strobe_tot - s0 != 1 || o_wr_addr !== 7'h0A || o_wr_data !== 8'h5C) begin
      fails++; $display("FAIL extra_edges strobes %0d addr %h data %h want 1 0a 5c", strobe_tot - s0, o_wr_addr, o_wr_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] rb, exp;
    logic [6:0] a;
    logic [15:0] w;
    int s0, o0, sel;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = (sel < 6) ? 7'($urandom_range(0, 15)) : (sel < 9) ? 7'($urandom_range(0, 127)) : 7'h78;
      w = {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
      exp = m_read(a);
      s0 = strobe_tot; o0 = oe_tot;
      frame(w, 16, rb);
      checks++;
      if (w[15]) begin
        if (rb !== exp || oe_tot - o0 != OE_LEN) begin
          fails++; $display("FAIL rand_read w=%h got %h oe %0d want %h oe %0d", w, rb, oe_tot - o0, exp, OE_LEN);
        end
      end else if (a < 7'd16) begin
        if (strobe_tot - s0 != 1 || o_wr_addr !== a || o_wr_data !== w[7:0]) begin
          fails++; $display("FAIL rand_write w=%h strobes %0d addr %h data %h", w, strobe_tot - s0, o_wr_addr, o_wr_data);
        end
      end else begin
        if (strobe_tot != s0) begin
          fails++; $display("FAIL rand_write_oor w=%h strobes %0d want 0", w, strobe_tot - s0);
        end
      end
    end
  endtask

`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
  task automatic test_frame_count();
    logic [7:0] rb;
    logic m;
    logic [15:0] c0;
    checks++;
    if (o_frame_count !== 16'(model_fc)) begin
      fails++; $display("FAIL frame_count_total got %0d want %0d", o_frame_count, model_fc);
    end
    c0 = o_frame_count;
    frame(16'h0201, 16, rb);
    frame(16'h8200, 16, rb);
    i_cs_n = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 10; i++) sclk_bit(1'b1, m);
    i_cs_n = 1'b1;
    repeat (2 * HP) @(negedge clk);
    frame(16'hF800, 16, rb);
    checks++;
    if (o_frame_count - c0 !== 16'd3) begin
      fails++; $display("FAIL frame_count_delta got %0d want 3", o_frame_count - c0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_whoami();
    test_out_of_range();
    test_abort();
    test_reset_mid_frame();
    test_extra_edges();
    test_random();
`ifdef SPI_REG_RESPONDER_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
